// File: rtl/branch_resolver.sv
// Branch resolver: in-order queue of fetch predictions checked against execute outcomes.
// Optional saturating statistics counters are enabled by defining BRES_STATS_EN.
module branch_resolver #(
  parameter int DEPTH     = 4,
  parameter int FLUSH_CYC = 2,
  parameter int STAT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_pc,
  input  logic                     push_predict,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  input  logic [31:0]              resolve_target,
  output logic                     upd_valid,
  output logic [31:0]              upd_pc,
  output logic                     upd_actual,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_empty,
  output logic [STAT_W-1:0]        stat_resolved,
  output logic [STAT_W-1:0]        stat_mispred
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_empty_q, err_empty_d;
  logic            upd_valid_q, upd_valid_d;
  logic [31:0]     upd_pc_q, upd_pc_d;
  logic            upd_actual_q, upd_actual_d;
  logic            mispredict_q, mispredict_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;

  logic [31:0]     mem_pc_q   [DEPTH];
  logic            mem_pred_q [DEPTH];

  logic            push_fire, pop_fire, mis, wr_en;
  logic [31:0]     head_pc;
  logic            head_pred;

  assign head_pc    = mem_pc_q[rd_ptr_q];
  assign head_pred  = mem_pred_q[rd_ptr_q];
  assign push_ready = (state_q == RUN) && (count_q < DEPTH_C);
  assign push_fire  = push_valid && push_ready;

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    err_empty_d   = err_empty_q;
    upd_valid_d   = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_actual_d  = upd_actual_q;
    mispredict_d  = 1'b0;
    redirect_pc_d = redirect_pc_q;
    pop_fire      = 1'b0;
    mis           = 1'b0;
    wr_en         = 1'b0;
    case (state_q)
      RUN: begin
        if (resolve_valid) begin
          if (count_q == '0) begin
            err_empty_d = 1'b1;
          end else begin
            pop_fire     = 1'b1;
            upd_valid_d  = 1'b1;
            upd_pc_d     = head_pc;
            upd_actual_d = resolve_taken;
            if (resolve_taken != head_pred) begin
              mis           = 1'b1;
              mispredict_d  = 1'b1;
              redirect_pc_d = resolve_taken ? resolve_target : head_pc + 32'd4;
            end
          end
        end
        if (mis) begin
          // Younger predictions are on the wrong path; a same-cycle push is dropped too.
          state_d     = FLUSH;
          flush_cnt_d = FW'(FLUSH_CYC - 1);
          count_d     = '0;
          rd_ptr_d    = wr_ptr_q;
        end else begin
          wr_en = push_fire;
          if (push_fire) wr_ptr_d = wr_ptr_q + PW'(1);
          if (pop_fire)  rd_ptr_d = rd_ptr_q + PW'(1);
          case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
          endcase
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = RUN;
        else                   flush_cnt_d = flush_cnt_q - FW'(1);
      end
      default: state_d = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_empty_q   <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_actual_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_empty_q   <= err_empty_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_actual_q  <= upd_actual_d;
      mispredict_q  <= mispredict_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // NOTE: queue storage is not reset; count/pointers guarantee stale entries are never read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_pc_q[wr_ptr_q]   <= push_pc;
      mem_pred_q[wr_ptr_q] <= push_predict;
    end
  end

  assign upd_valid   = upd_valid_q;
  assign upd_pc      = upd_pc_q;
  assign upd_actual  = upd_actual_q;
  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;
  assign count       = count_q;
  assign err_empty   = err_empty_q;

`ifdef BRES_STATS_EN
  logic [STAT_W-1:0] stat_resolved_q, stat_resolved_d, stat_mispred_q, stat_mispred_d;

  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (pop_fire && (stat_resolved_q != '1)) stat_resolved_d = stat_resolved_q + STAT_W'(1);
    if (mis && (stat_mispred_q != '1))       stat_mispred_d  = stat_mispred_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

endmodule
